// File: rtl/vu_vmu_dcache_resp_pkg.sv
// Shared definitions for the vector memory unit D$ responder.
// Holds the request op encodings, bus widths, the {tag,data} response
// bundle and small helpers used by the responder and its response pipe.
package vu_vmu_dcache_resp_pkg;

  localparam int unsigned DC_ADDR_SZ  = 30;
  localparam int unsigned DC_TAG_SZ   = 12;
  localparam int unsigned DC_DATA_SZ  = 64;
  localparam int unsigned DC_WMASK_SZ = 8;
  localparam int unsigned DC_OP_SZ    = 4;
  localparam int unsigned DC_RESP_SZ  = DC_TAG_SZ + DC_DATA_SZ;

  localparam logic [DC_OP_SZ-1:0] DC_OP_LD      = 4'b0000;
  localparam logic [DC_OP_SZ-1:0] DC_OP_ST      = 4'b0001;
  localparam logic [DC_OP_SZ-1:0] DC_OP_AMOSWAP = 4'b0100;
  localparam logic [DC_OP_SZ-1:0] DC_OP_AMOADD  = 4'b0101;
  localparam logic [DC_OP_SZ-1:0] DC_OP_AMOAND  = 4'b0110;
  localparam logic [DC_OP_SZ-1:0] DC_OP_AMOOR   = 4'b0111;

  typedef struct packed {
    logic [DC_TAG_SZ-1:0]  tag;
    logic [DC_DATA_SZ-1:0] data;
  } dc_resp_t;

  function automatic logic dc_op_is_amo(input logic [DC_OP_SZ-1:0] op);
    return (op == DC_OP_AMOSWAP) || (op == DC_OP_AMOADD) ||
           (op == DC_OP_AMOAND)  || (op == DC_OP_AMOOR);
  endfunction

  function automatic logic dc_op_legal(input logic [DC_OP_SZ-1:0] op);
    return (op == DC_OP_LD) || (op == DC_OP_ST) || dc_op_is_amo(op);
  endfunction

  // Byte-enable merge of new data over old data.
  function automatic logic [DC_DATA_SZ-1:0] dc_byte_merge(
    input logic [DC_DATA_SZ-1:0]  old_d,
    input logic [DC_DATA_SZ-1:0]  new_d,
    input logic [DC_WMASK_SZ-1:0] mask
  );
    logic [DC_DATA_SZ-1:0] r;
    for (int unsigned b = 0; b < DC_WMASK_SZ; b++) begin
      r[8*b +: 8] = mask[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/vu_vmu_dcache_resp_pipe.sv
// Fixed-latency response delay line carrying {tag,data} with a valid bit.
// Ports: clk, reset (async active-low, clears all stages),
//        in_val/in_bits (captured every edge), out_val/out_bits (LATENCY edges later).
module vu_vmu_dcache_resp_pipe
  import vu_vmu_dcache_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  input  logic [DC_RESP_SZ-1:0] in_bits,
  output logic                  out_val,
  output logic [DC_RESP_SZ-1:0] out_bits
);

  logic [LATENCY-1:0]    val_q;
  logic [DC_RESP_SZ-1:0] bits_q [LATENCY];

  // Shift register; reset drops every in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        bits_q[i] <= '0;
      end
    end else begin
      val_q[0]  <= in_val;
      bits_q[0] <= in_bits;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        val_q[i]  <= val_q[i-1];
        bits_q[i] <= bits_q[i-1];
      end
    end
  end

  assign out_val  = val_q[LATENCY-1];
  assign out_bits = bits_q[LATENCY-1];

endmodule

// File: rtl/vu_vmu_dcache_resp.sv
// Memory-side responder for the VMU D$ request/response interface.
// Services LD/ST/AMO against a local doubleword array; responses return a
// fixed LATENCY after acceptance with the tag echoed, in acceptance order.
// Ports: clk, reset (async active-low); dcachereq_{addr,tag,data,wmask,op,val}
//        in, dcachereq_rdy out; dcacheresp_{data,tag,val} out.
// Build option: VU_DCACHE_RANDSTALL_EN adds an LFSR that randomly drops rdy in IDLE.
module vu_vmu_dcache_resp
  import vu_vmu_dcache_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DC_ADDR_SZ-1:0]  dcachereq_addr,
  input  logic [DC_TAG_SZ-1:0]   dcachereq_tag,
  input  logic [DC_DATA_SZ-1:0]  dcachereq_data,
  input  logic [DC_WMASK_SZ-1:0] dcachereq_wmask,
  input  logic [DC_OP_SZ-1:0]    dcachereq_op,
  input  logic                   dcachereq_val,
  output logic                   dcachereq_rdy,
  output logic [DC_DATA_SZ-1:0]  dcacheresp_data,
  output logic [DC_TAG_SZ-1:0]   dcacheresp_tag,
  output logic                   dcacheresp_val
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_IDLE = 1'b0, ST_AMO_WR = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   rdy_q, rdy_d, stall_d;
  logic                   fire, is_st, is_amo;
  logic [DEPTH_LOG2-1:0]  idx;
  logic [DC_DATA_SZ-1:0]  rd_data;
  logic [DC_DATA_SZ-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  amo_idx;
  logic [DC_DATA_SZ-1:0]  amo_old, amo_opnd, amo_new;
  logic [DC_WMASK_SZ-1:0] amo_mask;
  logic [DC_OP_SZ-1:0]    amo_op;
  dc_resp_t               resp_in, resp_out;
  logic                   unused_addr;

  assign idx         = dcachereq_addr[DEPTH_LOG2+2:3];
  assign unused_addr = ^dcachereq_addr;
  assign rd_data     = mem[idx];
  assign fire        = dcachereq_val & dcachereq_rdy;
  assign is_st       = (dcachereq_op == DC_OP_ST);
  assign is_amo      = dc_op_is_amo(dcachereq_op);

  // rdy is held in a register; the reset term keeps it low during reset only.
  assign dcachereq_rdy = rdy_q & reset;

`ifdef VU_DCACHE_RANDSTALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall_d = (lfsr_d[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign stall_d = 1'b0;
`endif

  // FSM state and registered ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next state: an accepted AMO spends one extra cycle writing back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fire && is_amo) state_d = ST_AMO_WR;
      ST_AMO_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE) && !stall_d;
  end

  // AMO operands captured at accept; old value is the array content then.
  always_ff @(posedge clk) begin
    if (fire && is_amo) begin
      amo_idx  <= idx;
      amo_old  <= rd_data;
      amo_opnd <= dcachereq_data;
      amo_mask <= dcachereq_wmask;
      amo_op   <= dcachereq_op;
    end
  end

  function automatic logic [31:0] alu32(input logic [DC_OP_SZ-1:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    case (op)
      DC_OP_AMOSWAP: return b;
      DC_OP_AMOADD:  return a + b;
      DC_OP_AMOAND:  return a & b;
      DC_OP_AMOOR:   return a | b;
      default:       return a;
    endcase
  endfunction

  function automatic logic [63:0] alu64(input logic [DC_OP_SZ-1:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    case (op)
      DC_OP_AMOSWAP: return b;
      DC_OP_AMOADD:  return a + b;
      DC_OP_AMOAND:  return a & b;
      DC_OP_AMOOR:   return a | b;
      default:       return a;
    endcase
  endfunction

  // Half-word masks select a 32-bit op on that half; no carry crosses halves.
  always_comb begin
    if (amo_mask == 8'h0F) begin
      amo_new = {amo_old[63:32], alu32(amo_op, amo_old[31:0], amo_opnd[31:0])};
    end else if (amo_mask == 8'hF0) begin
      amo_new = {alu32(amo_op, amo_old[63:32], amo_opnd[63:32]), amo_old[31:0]};
    end else begin
      amo_new = alu64(amo_op, amo_old, amo_opnd);
    end
  end

  // Array write port: stores at accept, AMO write-back in AMO_WR.
  always_ff @(posedge clk) begin
    if (fire && is_st) begin
      mem[idx] <= dc_byte_merge(rd_data, dcachereq_data, dcachereq_wmask);
    end else if (state_q == ST_AMO_WR) begin
      mem[amo_idx] <= dc_byte_merge(amo_old, amo_new, amo_mask);
    end
  end

  // Unknown ops behave as loads but are flagged in simulation.
  always @(posedge clk) begin
    if (reset && fire) begin
      assert (dc_op_legal(dcachereq_op))
        else $error("vu_vmu_dcache_resp: illegal op %b handled as load", dcachereq_op);
    end
  end

  assign resp_in.tag  = dcachereq_tag;
  assign resp_in.data = rd_data;

  vu_vmu_dcache_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_val   (fire & ~is_st),
    .in_bits  (DC_RESP_SZ'(resp_in)),
    .out_val  (dcacheresp_val),
    .out_bits (resp_out)
  );

  assign dcacheresp_data = resp_out.data;
  assign dcacheresp_tag  = resp_out.tag;

endmodule

// File: tb/tb_vu_vmu_dcache_resp.sv
// Directed + random scoreboard bench for vu_vmu_dcache_resp.
// LAT sets the DUT latency (1..8). VU_DCACHE_RANDSTALL_EN is honoured.
module tb_vu_vmu_dcache_resp;
  import vu_vmu_dcache_resp_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] dcachereq_addr;
  logic [11:0] dcachereq_tag;
  logic [63:0] dcachereq_data;
  logic [7:0]  dcachereq_wmask;
  logic [3:0]  dcachereq_op;
  logic        dcachereq_val;
  logic        dcachereq_rdy;
  logic [63:0] dcacheresp_data;
  logic [11:0] dcacheresp_tag;
  logic        dcacheresp_val;

  typedef struct {
    logic [11:0] tag;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [1024];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_resp  = 0;
  int          cyc     = 0;

  vu_vmu_dcache_resp #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .dcachereq_addr  (dcachereq_addr),
    .dcachereq_tag   (dcachereq_tag),
    .dcachereq_data  (dcachereq_data),
    .dcachereq_wmask (dcachereq_wmask),
    .dcachereq_op    (dcachereq_op),
    .dcachereq_val   (dcachereq_val),
    .dcachereq_rdy   (dcachereq_rdy),
    .dcacheresp_data (dcacheresp_data),
    .dcacheresp_tag  (dcacheresp_tag),
    .dcacheresp_val  (dcacheresp_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_merge(input logic [63:0] o, input logic [63:0] n,
                                            input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Reference AMO: in 32-bit mode each half is evaluated on its own and
  // the mask then keeps only the selected half.
  function automatic logic [63:0] ref_amo(input logic [3:0] op, input logic [63:0] o,
                                          input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    logic [31:0] a, b;
    if (m == 8'h0F || m == 8'hF0) begin
      for (int h = 0; h < 2; h++) begin
        a = o[32*h +: 32];
        b = d[32*h +: 32];
        case (op)
          DC_OP_AMOSWAP: r[32*h +: 32] = b;
          DC_OP_AMOADD:  r[32*h +: 32] = a + b;
          DC_OP_AMOAND:  r[32*h +: 32] = a & b;
          default:       r[32*h +: 32] = a | b;
        endcase
      end
    end else begin
      case (op)
        DC_OP_AMOSWAP: r = d;
        DC_OP_AMOADD:  r = o + d;
        DC_OP_AMOAND:  r = o & d;
        default:       r = o | d;
      endcase
    end
    return ref_merge(o, r, m);
  endfunction

  // Present one request, wait (bounded) for acceptance, update model/scoreboard.
  task automatic req(input logic [3:0] op, input logic [29:0] addr, input logic [11:0] tag,
                     input logic [63:0] data, input logic [7:0] wmask);
    logic [9:0] i;
    exp_t       e;
    bit         done;
    i               = addr[12:3];
    dcachereq_op    = op;
    dcachereq_addr  = addr;
    dcachereq_tag   = tag;
    dcachereq_data  = data;
    dcachereq_wmask = wmask;
    dcachereq_val   = 1'b1;
    done            = 1'b0;
    for (int w = 0; w < 64 && !done; w++) begin
      @(negedge clk);
      if (dcachereq_rdy === 1'b1) begin
        done = 1'b1;
        if (op == DC_OP_ST) begin
          model[i] = ref_merge(model[i], data, wmask);
        end else begin
          e.tag  = tag;
          e.data = model[i];
          e.cyc  = cyc + LAT;
          sb.push_back(e);
          if (op != DC_OP_LD) model[i] = ref_amo(op, model[i], data, wmask);
        end
      end
      @(posedge clk);
      #1;
    end
    dcachereq_val = 1'b0;
    n_tests++;
    assert (done) else begin
      n_fail++;
      $error("FAIL req_accept tag=%h observed=not_accepted expected=accepted", tag);
    end
  endtask

  task automatic drain();
    for (int w = 0; w < int'(LAT) + 40 && sb.size() != 0; w++) @(negedge clk);
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && dcacheresp_val === 1'b1) begin
      n_resp++;
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL resp_unexpected observed tag=%h expected=no_response", dcacheresp_tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_tag",   64'(dcacheresp_tag), 64'(e.tag));
        chk("resp_data",  dcacheresp_data, e.data);
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [3:0] ops [6];
    logic [3:0] op;
    logic [7:0] m;
    int         r0;
    ops = '{DC_OP_LD, DC_OP_ST, DC_OP_AMOSWAP, DC_OP_AMOADD, DC_OP_AMOAND, DC_OP_AMOOR};

    reset           = 1'b0;
    dcachereq_val   = 1'b0;
    dcachereq_addr  = '0;
    dcachereq_tag   = '0;
    dcachereq_data  = '0;
    dcachereq_wmask = '0;
    dcachereq_op    = '0;

    // Reset held 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",       64'(dcachereq_rdy), 64'd0);
    chk("rst_resp_val",  64'(dcacheresp_val), 64'd0);
    chk("rst_resp_tag",  64'(dcacheresp_tag), 64'd0);
    chk("rst_resp_data", dcacheresp_data, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_release",      64'(dcachereq_rdy), 64'd1);
    chk("resp_val_after_release", 64'(dcacheresp_val), 64'd0);
    @(posedge clk);
    #1;

    // Store then load back-to-back.
    req(DC_OP_ST, 30'h40, 12'h000, 64'h1122334455667788, 8'hFF);
    req(DC_OP_LD, 30'h40, 12'h0A5, 64'h0, 8'h00);
    drain();

    // Byte-masked store, load via unaligned byte address.
    req(DC_OP_ST, 30'h40, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0C);
    req(DC_OP_LD, 30'h43, 12'h35A, 64'h0, 8'h00);
    drain();

    // 32-bit AMOADD on the low half: no carry into the upper half.
    req(DC_OP_ST, 30'h80, 12'h000, 64'h00000001_FFFFFFFF, 8'hFF);
    req(DC_OP_AMOADD, 30'h80, 12'h7C1, 64'h1, 8'h0F);
`ifndef VU_DCACHE_RANDSTALL_EN
    @(negedge clk);
    chk("amo_wr_rdy_low", 64'(dcachereq_rdy), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("amo_done_rdy_high", 64'(dcachereq_rdy), 64'd1);
    @(posedge clk);
    #1;
`endif
    req(DC_OP_LD, 30'h80, 12'h7C2, 64'h0, 8'h00);
    drain();

    // 16 back-to-back loads, tags 0..15.
    for (int i = 0; i < 16; i++) begin
      req(DC_OP_LD, (i % 2 == 0) ? 30'h40 : 30'h80, 12'(i), 64'h0, 8'h00);
    end
    drain();

    // Reset with two loads in flight: nothing further may emerge.
    req(DC_OP_LD, 30'h40, 12'h111, 64'h0, 8'h00);
    req(DC_OP_LD, 30'h40, 12'h222, 64'h0, 8'h00);
    reset = 1'b0;
    sb.delete();
    r0 = n_resp;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("reset_drop_count", 64'(n_resp - r0), 64'd0);
    @(posedge clk);
    #1;

    // Random mix against the reference model over 8 initialised doublewords.
    for (int k = 0; k < 8; k++) begin
      req(DC_OP_ST, 30'(32'h100 + 8 * k), 12'h0, {$urandom, $urandom}, 8'hFF);
    end
    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0:       m = 8'hFF;
        1:       m = 8'h0F;
        2:       m = 8'hF0;
        default: m = 8'($urandom);
      endcase
      req(op, 30'(32'h100 + 8 * $urandom_range(0, 7) + $urandom_range(0, 7)),
          12'($urandom), {$urandom, $urandom}, m);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
